mdu_sched: RTL

- Sequencing controller for the multiply/divide resource in the E stage of the five-stage pipeline.
- Accepts one MDU operation per start pulse and latches the operands.
- Models the fixed multi-cycle latency with a down-counter, owns the HI/LO registers and drives the busy signal.
- Produces the D-stage stall request consumed by the hazard unit, so no MDU instruction issues into an occupied unit.

---
 rtl/mdu_sched_if.sv | 25 ++
 rtl/mdu_sched.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mdu_sched_if.sv
// Bundle between the E stage and the MDU sequencer: operation request,
// operands, hazard-unit stall request and the HI/LO result path.
interface mdu_sched_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        d_is_mdu;
  logic        busy;
  logic        stall_req;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  modport master (
    output start, op, rs, rt, d_is_mdu,
    input  busy, stall_req, out, hi, lo, done
  );

  modport slave (
    input  start, op, rs, rt, d_is_mdu,
    output busy, stall_req, out, hi, lo, done
  );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: latches operands, counts out a fixed latency,
// commits HI/LO and requests D-stage stalls while the unit is occupied.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_sched_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [3:0]  op_reg, op_next;
  logic [31:0] rs_reg, rs_next;
  logic [31:0] rt_reg, rt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        done_reg, done_next;

  logic               start_muldiv;
  logic signed [63:0] a_ext, b_ext;
  logic [63:0]        prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] divisor_s, quot_s, rem_s;
  logic [31:0]        divisor_u, quot_u, rem_u;

  assign start_muldiv = bus.start && (bus.op >= 4'd1) && (bus.op <= 4'd4);

  // Arithmetic always works on the latched operands.
  assign a_ext  = {{32{rs_reg[31]}}, rs_reg};
  assign b_ext  = {{32{rt_reg[31]}}, rt_reg};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {32'd0, rs_reg} * {32'd0, rt_reg};

  // Divisor is forced to 1 for the zero and MIN/-1 cases so the divider never
  // sees an undefined operation; MIN/1 already yields the required MIN, 0.
  assign div_zero  = (rt_reg == 32'd0);
  assign div_ovf   = (rs_reg == 32'h8000_0000) && (rt_reg == 32'hFFFF_FFFF);
  assign divisor_s = (div_zero || div_ovf) ? 32'sd1 : $signed(rt_reg);
  assign quot_s    = $signed(rs_reg) / divisor_s;
  assign rem_s     = $signed(rs_reg) % divisor_s;
  assign divisor_u = div_zero ? 32'd1 : rt_reg;
  assign quot_u    = rs_reg / divisor_u;
  assign rem_u     = rs_reg % divisor_u;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      op_reg    <= 4'd0;
      rs_reg    <= 32'd0;
      rt_reg    <= 32'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      rs_reg    <= rs_next;
      rt_reg    <= rt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    op_next    = op_reg;
    rs_next    = rs_reg;
    rt_next    = rt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_muldiv) begin
          state_next = RUN;
          op_next    = bus.op;
          rs_next    = bus.rs;
          rt_next    = bus.rt;
          count_next = (bus.op <= 4'd2) ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
        end else if (bus.start && bus.op == 4'd7) begin
          hi_next = bus.rs;
        end else if (bus.start && bus.op == 4'd8) begin
          lo_next = bus.rs;
        end
      end
      RUN: begin
        // Any start arriving here is deliberately ignored.
        if (count_reg == 4'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
          case (op_reg)
            4'd1: {hi_next, lo_next} = prod_s;
            4'd2: {hi_next, lo_next} = prod_u;
            4'd3: if (!div_zero) begin
              lo_next = quot_s;
              hi_next = rem_s;
            end
            4'd4: if (!div_zero) begin
              lo_next = quot_u;
              hi_next = rem_u;
            end
            default: ;
          endcase
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg == RUN);
  assign bus.stall_req = bus.d_is_mdu && (bus.busy || start_muldiv);
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
  assign bus.done      = done_reg;

  always_comb begin
    bus.out = 32'd0;
    if (bus.op == 4'd5)      bus.out = hi_reg;
    else if (bus.op == 4'd6) bus.out = lo_reg;
  end

endmodule
